// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: accepts one request, then computes the result
// one bit per clock (LSB first) through a single-bit slice with a carry
// register. The result, carry out and zero flag are held until the consumer
// accepts them.
module serial_alu_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] OP1,
   input  logic [WIDTH-1:0] OP2,
   input  logic [2:0]       opsel,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
);

   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic             mode_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             zero_q;
   logic             out_valid_q;
   logic             in_ready_q;

   logic             bit_d;
   logic             carry_d;
   logic [WIDTH-1:0] result_d;

   // Initial carry: set for subtract (two's complement +1) and increment.
   function automatic logic init_carry(input logic [2:0] op, input logic md);
      return (md == 1'b0) && ((op == 3'b001) || (op == 3'b010));
   endfunction

   // One bit of the ALU; returns {carry_out, result_bit}.
   // For the logic shift the carry register carries A[i-1] into bit i.
   function automatic logic [1:0] slice(input logic a, input logic b, input logic c,
                                        input logic [2:0] op, input logic md);
      logic bp;
      logic [1:0] r;
      r  = 2'b00;
      bp = 1'b0;
      if (md == 1'b0) begin
         if (op[2] == 1'b0) begin
            case (op[1:0])
               2'b00:   bp = b;
               2'b01:   bp = ~b;
               2'b10:   bp = 1'b0;
               default: bp = 1'b1;
            endcase
            r = {(a & bp) | (a & c) | (bp & c), a ^ bp ^ c};
         end
      end else begin
         case (op)
            3'b000:  r = {1'b0, a & b};
            3'b001:  r = {1'b0, a | b};
            3'b010:  r = {1'b0, a ^ b};
            3'b011:  r = {1'b0, ~a};
            3'b100:  r = {a, c};
            default: r = 2'b00;
         endcase
      end
      return r;
   endfunction

   // Current bit slice and the result word with that bit merged in.
   always_comb begin
      {carry_d, bit_d} = slice(a_q[idx_q], b_q[idx_q], carry_q, op_q, mode_q);
      result_d         = result_q;
      result_d[idx_q]  = bit_d;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 3'b000;
         mode_q      <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= OP1;
                  b_q        <= OP2;
                  op_q       <= opsel;
                  mode_q     <= mode;
                  idx_q      <= '0;
                  carry_q    <= init_carry(opsel, mode);
                  result_q   <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= carry_d;
               if (idx_q == LAST_IDX) begin
                  cout_q      <= carry_d;
                  zero_q      <= (result_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer at WIDTH=8.
module tb_serial_alu_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] OP1;
   logic [W-1:0] OP2;
   logic [2:0]   opsel;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;

   int n_cmp;
   int n_bad;

   serial_alu_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .OP1       (OP1),
      .OP2       (OP2),
      .opsel     (opsel),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request and check exact latency and the presented result.
   task automatic do_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic md,
                         input logic [W-1:0] er, input logic ec, input logic ez);
      OP1 = a; OP2 = b; opsel = op; mode = md; in_valid = 1'b1;
      check({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      OP1 = ~a; OP2 = ~b; opsel = op ^ 3'b101; mode = ~md;
      check({tag, ".ready_run"}, 32'(in_ready), 32'd0);
      repeat (7) step();
      check({tag, ".valid_e7"}, 32'(out_valid), 32'd0);
      step();
      check({tag, ".valid_e8"}, 32'(out_valid), 32'd1);
      check({tag, ".result"}, 32'(result), 32'(er));
      check({tag, ".cout"}, 32'(cout), 32'(ec));
      check({tag, ".zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, ".valid_rel"}, 32'(out_valid), 32'd0);
      check({tag, ".ready_rel"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      OP1 = '0; OP2 = '0; opsel = 3'b000; mode = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.result", 32'(result), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.zero", 32'(zero), 32'd0);

      do_req("add_ovf", 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1);
      release_out("add_ovf");
      do_req("sub_neg", 8'h05, 8'h07, 3'b001, 1'b0, 8'hFE, 1'b0, 1'b0);
      release_out("sub_neg");
      do_req("sub_pos", 8'h07, 8'h05, 3'b001, 1'b0, 8'h02, 1'b1, 1'b0);
      release_out("sub_pos");
      do_req("shl", 8'h81, 8'h00, 3'b100, 1'b1, 8'h02, 1'b1, 1'b0);
      release_out("shl");
      do_req("inc", 8'h7F, 8'h55, 3'b010, 1'b0, 8'h80, 1'b0, 1'b0);
      release_out("inc");
      do_req("dec0", 8'h00, 8'h55, 3'b011, 1'b0, 8'hFF, 1'b0, 1'b0);
      release_out("dec0");
      do_req("and", 8'hF0, 8'h3C, 3'b000, 1'b1, 8'h30, 1'b0, 1'b0);
      release_out("and");
      do_req("or", 8'hF0, 8'h3C, 3'b001, 1'b1, 8'hFC, 1'b0, 1'b0);
      release_out("or");
      do_req("not", 8'h0F, 8'hFF, 3'b011, 1'b1, 8'hF0, 1'b0, 1'b0);
      release_out("not");
      do_req("lres", 8'hFF, 8'hFF, 3'b110, 1'b1, 8'h00, 1'b0, 1'b1);
      release_out("lres");

      // XOR held under backpressure; an in_valid pulse must be ignored.
      do_req("xor", 8'hF0, 8'h3C, 3'b010, 1'b1, 8'hCC, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            OP1 = 8'h11; OP2 = 8'h22; opsel = 3'b000; mode = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         check("bp.valid", 32'(out_valid), 32'd1);
         check("bp.result", 32'(result), 32'hCC);
         check("bp.cout", 32'(cout), 32'd0);
         check("bp.zero", 32'(zero), 32'd0);
         check("bp.in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_out("xor");
      do_req("ares", 8'hAA, 8'h55, 3'b111, 1'b0, 8'h00, 1'b0, 1'b1);
      release_out("ares");

      // Reset while bit 3 is due; in_valid during reset is ignored.
      OP1 = 8'h33; OP2 = 8'h44; opsel = 3'b000; mode = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0; in_valid = 1'b1;
      step();
      rst_n = 1'b1; in_valid = 1'b0;
      check("rmid.in_ready", 32'(in_ready), 32'd1);
      check("rmid.out_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("rmid.idle_valid", 32'(out_valid), 32'd0);
         check("rmid.idle_ready", 32'(in_ready), 32'd1);
      end
      do_req("post_rst", 8'h10, 8'h20, 3'b000, 1'b0, 8'h30, 1'b0, 1'b0);
      release_out("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_alu_sequencer.md
SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports OP1 and OP2, input, WIDTH bits each: operands A and B.
REQ-007 The block SHALL have port opsel, input, 3 bits: operation select.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 selects arithmetic, 1 selects logic.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the assembled result.
REQ-012 The block SHALL have port cout, output, 1 bit: the final carry out.
REQ-013 The block SHALL have port zero, output, 1 bit: high when result equals 0.

Function
REQ-014 The block SHALL use a 3-state FSM.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when in_valid and in_ready are both high.
- RUN -> DONE after bit WIDTH-1 is processed.
- DONE -> IDLE when out_ready is high.
REQ-015 in_ready SHALL be high only in IDLE; in_valid in RUN or DONE SHALL be ignored and has no side effect.
REQ-016 On the accepting edge, the block SHALL:
- latch OP1, OP2, opsel and mode;
- clear the bit index to 0;
- load the carry register with its initial value from REQ-019.
REQ-017 In RUN, the block SHALL process exactly one bit per clock, LSB first, at bit index i = 0..WIDTH-1.
- result[i] SHALL be written from slice(A[i], B'[i], carry).
- The carry register SHALL be updated with the slice carry out.
REQ-018 out_valid SHALL rise on the WIDTH-th rising edge after the accepting edge.
- The next request is accepted no earlier than the edge after the out_ready handshake, so there is one idle bubble minimum.
REQ-019 Arithmetic operations (mode=0) SHALL be as follows (B' = effective B, c0 = initial carry):
- 000: A+B; B'=B, c0=0.
- 001: A-B; B'=~B, c0=1; cout=1 means no borrow.
- 010: A+1; B'=0, c0=1.
- 011: A-1; B'=all ones, c0=0.
- 100-111: reserved; result=0, cout=0.
REQ-020 Logic operations (mode=1) SHALL be as follows; cout=0 unless stated:
- 000: AND.
- 001: OR.
- 010: XOR.
- 011: NOT A (B ignored).
- 100: shift left by 1. The carry register holds A[i-1] and c0=0, so result[i]=A[i-1], result[0]=0, cout=A[WIDTH-1].
- 101-111: reserved; result=0, cout=0.
REQ-021 All arithmetic SHALL be modulo 2^WIDTH; cout SHALL be the carry out of bit WIDTH-1, held in the carry register.
REQ-022 result, cout and zero SHALL be registered and SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 result, cout and zero SHALL be don't-care while out_valid is low.
REQ-024 A changing OP1, OP2, opsel or mode after acceptance SHALL NOT affect the operation in progress.
REQ-025 The bit index SHALL count 0..WIDTH-1 with no wrap-around in RUN.

Reset
REQ-026 When rst_n is low at a rising edge, the block SHALL:
- enter IDLE;
- clear the bit index, carry, result, cout and zero to 0;
- drive out_valid=0 and in_ready=1 from the following cycle.
REQ-027 A reset asserted in RUN or DONE SHALL abort the operation; the aborted result SHALL never be presented.
REQ-028 in_valid SHALL be ignored during any cycle in which rst_n is low.

Verification (WIDTH=8)
REQ-029 The bench SHALL check add with overflow: mode=0, opsel=000, OP1=0xFF, OP2=0x01 -> after 8 edges, result=0x00, cout=1, zero=1.
REQ-030 The bench SHALL check subtract in both directions:
- 0x05-0x07 -> result=0xFE, cout=0.
- 0x07-0x05 -> result=0x02, cout=1.
REQ-031 The bench SHALL check shift left: mode=1, opsel=100, OP1=0x81 -> result=0x02, cout=1, zero=0.
REQ-032 The bench SHALL check backpressure and a reserved code:
- mode=1, opsel=010, 0xF0 XOR 0x3C -> result=0xCC.
- out_ready held low 5 cycles -> outputs stable, in_ready=0, and an in_valid pulse is ignored.
- After out_ready: IDLE, then a reserved mode=0 opsel=111 -> result=0x00, cout=0.
REQ-033 The bench SHALL check reset mid-operation: rst_n low at bit 3 of a run -> next cycle in_ready=1, out_valid=0.
- A new A+B request 0x10+0x20 then yields result=0x30, cout=0 with exact 8-edge latency.
